// File: rtl/fp_pkg.sv
// Shared types and bit-pattern helpers for the sequential floating-point adder.
package fp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    localparam int unsigned FLAGS_W        = 4;
    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Positive infinity: all-ones exponent, zero fraction.
    function automatic logic [63:0] inf_pat(input int unsigned exp_w, input int unsigned man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
    function automatic logic [63:0] qnan_pat(input int unsigned exp_w, input int unsigned man_w);
        return inf_pat(exp_w, man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Issue-port bundle between a requester and the sequential floating-point adder.
interface fp_addsub_seq_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         done;
    logic         busy;
    logic [3:0]   flags;

    modport master (output start, op, a, b, input sum, done, busy, flags);
    modport slave  (input start, op, a, b, output sum, done, busy, flags);
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 27
) (
    input  logic [WIDTH-1:0]            value,
    output logic [$clog2(WIDTH+1)-1:0]  count
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit is the last to write.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (value[i]) count = CW'(int'(WIDTH) - 1 - i);
        end
    end
endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/sub: unpack, align, add, normalise, round (RNE), fixed 6-cycle latency.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic           clk,
    input logic           reset,
    fp_addsub_seq_if.slave bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned DW = MAN_W + 4;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [EXP_W-1:0] EMAX    = '1;
    localparam logic [W-2:0]     INF_MAG = (W-1)'(inf_pat(EXP_W, MAN_W));
    localparam logic [W-1:0]     QNAN    = W'(qnan_pat(EXP_W, MAN_W));

    state_e state_q, state_d;
    logic op_q, op_d, sa_q, sa_d, sb_q, sb_d, byp_q, byp_d, sx_q, sx_d, sub_q, sub_d;
    logic rs_q, rs_d, ns_q, ns_d, nzero_q, nzero_d, nuf_q, nuf_d, done_q, done_d, busy_q, busy_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, byp_sum_q, byp_sum_d, sum_q, sum_d;
    logic [3:0]         byp_flags_q, byp_flags_d, flags_q, flags_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d, ex_q, ex_d;
    logic [MAN_W:0]     ma_q, ma_d, mb_q, mb_d;
    logic [DW-1:0]      mx_q, mx_d, my_q, my_d, nm_q, nm_d;
    logic [DW:0]        r_q, r_d;
    logic [EW-1:0]      re_q, re_d, ne_q, ne_d;

    // Unpack: classify operands, b sign folded with op; subnormals count as zero.
    logic             ua_s, ub_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ua_e, ub_e;
    logic [MAN_W-1:0] ua_f, ub_f;
    assign ua_s   = a_q[W-1];
    assign ub_s   = b_q[W-1] ^ op_q;
    assign ua_e   = a_q[W-2:MAN_W];
    assign ub_e   = b_q[W-2:MAN_W];
    assign ua_f   = a_q[MAN_W-1:0];
    assign ub_f   = b_q[MAN_W-1:0];
    assign a_zero = (ua_e == '0);
    assign b_zero = (ub_e == '0);
    assign a_inf  = (ua_e == EMAX) && (ua_f == '0);
    assign b_inf  = (ub_e == EMAX) && (ub_f == '0);
    assign a_nan  = (ua_e == EMAX) && (ua_f != '0);
    assign b_nan  = (ub_e == EMAX) && (ub_f != '0);

    // Align: larger magnitude becomes X; Y shifted right with G/R/S kept.
    logic             al_ge;
    logic [EXP_W-1:0] al_ex, al_ey, al_diff;
    logic [MAN_W:0]   al_mx, al_my;
    logic [DW-1:0]    al_yext, al_ysh;
    assign al_ge   = {ea_q, ma_q} >= {eb_q, mb_q};
    assign al_ex   = al_ge ? ea_q : eb_q;
    assign al_ey   = al_ge ? eb_q : ea_q;
    assign al_mx   = al_ge ? ma_q : mb_q;
    assign al_my   = al_ge ? mb_q : ma_q;
    assign al_diff = al_ex - al_ey;
    assign al_yext = {al_my, 3'b000};
    assign al_ysh  = (32'(al_diff) >= MAN_W + 3) ? DW'(al_my != '0)
                   : ((al_yext >> al_diff) | DW'(|(al_yext & ~({DW{1'b1}} << al_diff))));

    logic [CW-1:0] lz;
    fp_lzc #(.WIDTH(DW)) u_lzc (.value(r_q[DW-1:0]), .count(lz));

    // Normalise: carry shifts right with sticky, otherwise left by the leading-zero count.
    logic          nz_zero;
    logic [DW-1:0] nz_m;
    logic [EW-1:0] nz_e;
    assign nz_zero = (r_q == '0);
    assign nz_m    = r_q[DW] ? {r_q[DW:2], r_q[1] | r_q[0]} : (r_q[DW-1:0] << lz);
    assign nz_e    = r_q[DW] ? (re_q + EW'(1)) : (re_q - EW'(lz));

    // Round to nearest even; a fraction carry renormalises to 1.0 at exp+1.
    logic             rd_inc, rd_ovf, rd_inexact;
    logic [MAN_W+1:0] rd_m;
    logic [MAN_W-1:0] rd_frac;
    logic [EW-1:0]    rd_e;
    assign rd_inc     = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    assign rd_m       = {1'b0, nm_q[DW-1:3]} + (MAN_W+2)'(rd_inc);
    assign rd_e       = ne_q + EW'(rd_m[MAN_W+1]);
    assign rd_frac    = rd_m[MAN_W+1] ? rd_m[MAN_W:1] : rd_m[MAN_W-1:0];
    assign rd_ovf     = rd_e >= EW'(EMAX);
    assign rd_inexact = |nm_q[2:0];

    always_comb begin
        state_d = state_q;  op_d = op_q;  a_d = a_q;  b_d = b_q;
        sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
        byp_d = byp_q;  byp_sum_d = byp_sum_q;  byp_flags_d = byp_flags_q;
        sx_d = sx_q;  sub_d = sub_q;  ex_d = ex_q;  mx_d = mx_q;  my_d = my_q;
        r_d = r_q;  rs_d = rs_q;  re_d = re_q;
        nm_d = nm_q;  ne_d = ne_q;  ns_d = ns_q;  nzero_d = nzero_q;  nuf_d = nuf_q;
        sum_d = sum_q;  flags_d = flags_q;  done_d = 1'b0;  busy_d = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d = bus.a;  b_d = bus.b;  op_d = bus.op;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d = ua_s;  sb_d = ub_s;  ea_d = ua_e;  eb_d = ub_e;
                ma_d = {1'b1, ua_f};  mb_d = {1'b1, ub_f};
                byp_d = 1'b1;  byp_flags_d = '0;  byp_sum_d = a_q;
                if (a_nan || b_nan) begin
                    byp_sum_d = QNAN;
                end else if (a_inf && b_inf && (ua_s != ub_s)) begin
                    byp_sum_d = QNAN;
                    byp_flags_d[FLAG_INVALID] = 1'b1;
                end else if (a_inf)            byp_sum_d = {ua_s, INF_MAG};
                else if (b_inf)                byp_sum_d = {ub_s, INF_MAG};
                else if (a_zero && b_zero)     byp_sum_d = {ua_s & ub_s, (W-1)'(0)};
                else if (a_zero)               byp_sum_d = {ub_s, b_q[W-2:0]};
                else if (!b_zero)              byp_d = 1'b0;
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                sx_d  = al_ge ? sa_q : sb_q;
                sub_d = sa_q ^ sb_q;
                ex_d  = al_ex;
                mx_d  = {al_mx, 3'b000};
                my_d  = al_ysh;
                state_d = S_ADD;
            end
            S_ADD: begin
                r_d  = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
                rs_d = sx_q;
                re_d = EW'(ex_q);
                state_d = S_NORM;
            end
            S_NORM: begin
                nm_d = nz_m;  ne_d = nz_e;  ns_d = rs_q;  nzero_d = nz_zero;
                nuf_d = !nz_zero && (nz_e[EW-1] || (nz_e == '0));
                state_d = S_ROUND;
            end
            S_ROUND: begin
                flags_d = '0;
                if (byp_q) begin
                    sum_d = byp_sum_q;  flags_d = byp_flags_q;
                end else if (nzero_q) begin
                    sum_d = '0;
                end else if (nuf_q) begin
                    sum_d = {ns_q, (W-1)'(0)};
                    flags_d[FLAG_UNDERFLOW] = 1'b1;  flags_d[FLAG_INEXACT] = 1'b1;
                end else if (rd_ovf) begin
                    sum_d = {ns_q, INF_MAG};
                    flags_d[FLAG_OVERFLOW] = 1'b1;  flags_d[FLAG_INEXACT] = 1'b1;
                end else begin
                    sum_d = {ns_q, rd_e[EXP_W-1:0], rd_frac};
                    flags_d[FLAG_INEXACT] = rd_inexact;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Datapath staging needs no reset; the FSM decides when each stage is valid.
    always_ff @(posedge clk) begin
        op_q <= op_d;  a_q <= a_d;  b_q <= b_d;
        sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
        byp_q <= byp_d;  byp_sum_q <= byp_sum_d;  byp_flags_q <= byp_flags_d;
        sx_q <= sx_d;  sub_q <= sub_d;  ex_q <= ex_d;  mx_q <= mx_d;  my_q <= my_d;
        r_q <= r_d;  rs_q <= rs_d;  re_q <= re_d;
        nm_q <= nm_d;  ne_q <= ne_d;  ns_q <= ns_d;  nzero_q <= nzero_d;  nuf_q <= nuf_d;
    end

    assign bus.sum   = sum_q;
    assign bus.flags = flags_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed scoreboard bench for fp_addsub_seq: single and half precision instances.
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
    fp_addsub_seq_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    int checks = 0;
    int errors = 0;
    logic [35:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel16, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
        if (sel16) begin
            bus16.start = s; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.op = op;
        end else begin
            bus32.start = s; bus32.a = a; bus32.b = b; bus32.op = op;
        end
    endtask

    task automatic read_out(input bit sel16, output logic [31:0] s, output logic [3:0] f,
                            output logic d, output logic bz);
        if (sel16) begin
            s = {16'h0, bus16.sum}; f = bus16.flags; d = bus16.done; bz = bus16.busy;
        end else begin
            s = bus32.sum; f = bus32.flags; d = bus32.done; bz = bus32.busy;
        end
    endtask

    // Entered and left on a falling edge; the caller may start the next op immediately.
    task automatic run_op(input bit sel16, input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] es, input logic [3:0] ef, input string tag,
                          input bit poke_busy, input bit poke_done);
        logic [31:0] s;
        logic [3:0]  f;
        logic        d, bz, busy_ok;
        logic [35:0] exp;
        int lat;
        drive(sel16, 1'b1, a, b, op);
        sb.push_back({es, ef});
        @(negedge clk);
        drive(sel16, 1'b0, a, b, op);
        lat = 1;
        busy_ok = 1'b1;
        read_out(sel16, s, f, d, bz);
        while (!d && lat < 20) begin
            if (!bz) busy_ok = 1'b0;
            if (poke_busy && lat == 2) drive(sel16, 1'b1, 32'h7F800000, 32'hFF800000, 1'b1);
            else drive(sel16, 1'b0, a, b, op);
            @(negedge clk);
            lat++;
            read_out(sel16, s, f, d, bz);
        end
        chk({tag, ":done_seen"}, 32'(d), 32'd1);
        if (d) begin
            chk({tag, ":latency"}, 32'(lat), 32'd6);
            chk({tag, ":busy"}, 32'(bz & busy_ok), 32'd1);
            exp = sb.pop_front();
            chk({tag, ":sum"}, s, exp[35:4]);
            chk({tag, ":flags"}, 32'(f), 32'(exp[3:0]));
        end else begin
            sb.delete();
        end
        if (poke_done) drive(sel16, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
        @(negedge clk);
        drive(sel16, 1'b0, a, b, op);
        read_out(sel16, s, f, d, bz);
        chk({tag, ":busy_after"}, 32'(bz), 32'd0);
        chk({tag, ":done_after"}, 32'(d), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic [3:0]  f;
        logic        d, bz, seen;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        read_out(1'b0, s, f, d, bz);
        chk("reset:sum", s, 32'h0);
        chk("reset:flags", 32'(f), 32'h0);
        chk("reset:done", 32'(d), 32'h0);
        chk("reset:busy", 32'(bz), 32'h0);
        read_out(1'b1, s, f, d, bz);
        chk("reset16:sum", s, 32'h0);
        chk("reset16:busy", 32'(bz), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000, "one_plus_two", 0, 0);
        run_op(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'b0000, "one_minus_one", 0, 0);
        run_op(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000, "negzero_sum", 0, 0);
        run_op(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001, "tie_to_even", 0, 0);
        run_op(0, 32'h3F800000, 32'h34400000, 0, 32'h3F800002, 4'b0001, "round_up", 0, 0);
        run_op(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'b1000, "inf_minus_inf", 0, 0);
        run_op(0, 32'h7FA00000, 32'h3F800000, 0, 32'h7FC00000, 4'b0000, "nan_in", 0, 0);
        run_op(0, 32'h00000001, 32'h3F800000, 0, 32'h3F800000, 4'b0000, "ftz", 0, 0);
        run_op(0, 32'h40400000, 32'hBF800000, 0, 32'h40000000, 4'b0000, "three_plus_negone", 0, 0);
        run_op(0, 32'h3F800000, 32'hC0000000, 1, 32'h40400000, 4'b0000, "one_sub_negtwo", 0, 0);
        run_op(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000, "start_while_busy", 1, 1);
        run_op(0, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 4'b0000, "back_to_back", 0, 0);
        run_op(0, 32'h00800001, 32'h00800000, 1, 32'h00000000, 4'b0011, "underflow", 0, 0);
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101, "overflow", 0, 0);

        // Abort in ALIGN: outputs clear and no done follows.
        drive(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_out(1'b0, s, f, d, bz);
        chk("abort:sum", s, 32'h0);
        chk("abort:flags", 32'(f), 32'h0);
        chk("abort:done", 32'(d), 32'h0);
        chk("abort:busy", 32'(bz), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            read_out(1'b0, s, f, d, bz);
            seen = seen | d;
        end
        chk("abort:no_done", 32'(seen), 32'h0);

        // Reset and start in the same cycle: reset wins.
        reset = 1'b1;
        drive(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        read_out(1'b0, s, f, d, bz);
        chk("reset_vs_start:busy", 32'(bz), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            read_out(1'b0, s, f, d, bz);
            seen = seen | d | bz;
        end
        chk("reset_vs_start:idle", 32'(seen), 32'h0);

        run_op(1, 32'h00003C00, 32'h00004000, 0, 32'h00004200, 4'b0000, "half_one_plus_two", 0, 0);
        run_op(1, 32'h00003C00, 32'h00003C00, 1, 32'h00000000, 4'b0000, "half_one_minus_one", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
